mem_frame_sampler: RTL and testbench
====================================

# mem_frame_sampler

Scans the four tactile channels of the MEM frame and produces one averaged memristor/piezo sample pair per channel for the downstream manipulator-control decision stage. For each channel it:
- selects the channel on the analog mux and waits for settling;
- runs 2^AVG_LOG2 dual-input ADC conversions and averages them;
- publishes the result with a one-hot channel tag and a one-cycle ready pulse.

It sits between the ADC interface and the control stage, and drives that stage's memristor_ref / piezo_ref / ch_sign_i / control_rdy inputs.

## Interface
- SETTLE_CYC, 16: cycles spent in SETTLE after each mux change (≥1).
- AVG_LOG2, 2: log2 of conversions averaged per channel (0..4).
- ADC_TIMEOUT, 1023: max cycles to wait for adc_done before the channel is aborted.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run continuous frame scanning.
- ch_mask  in  4  channels included in a frame; bit i = channel i.
- err_clr  in  1  clears timeout_err.
- mux_sel  out  4  one-hot analog mux select.
- adc_start  out  1  one-cycle conversion request.
- adc_done  in  1  conversion complete; adc_mem and adc_piezo valid this cycle.
- adc_mem  in  16  memristor conversion result.
- adc_piezo  in  16  piezo conversion result.
- memristor_ref  out  16  averaged memristor value of the last published channel.
- piezo_ref  out  16  averaged piezo value of the last published channel.
- ch_sign_o  out  4  one-hot tag of the published channel.
- control_rdy  out  1  one-cycle publish strobe.
- frame_done  out  1  one-cycle strobe after the last masked channel of a frame.
- timeout_err  out  1  sticky ADC-timeout flag.

## Operation
- States: IDLE, SETTLE, CONVERT, WAIT_DONE, PUBLISH, NEXT.
- IDLE:
  - If enable=1 and ch_mask≠0, latch ch_mask into frame_mask, select the lowest set bit, and go to SETTLE.
  - Otherwise remain in IDLE.
- SETTLE:
  - mux_sel drives the selected channel.
  - Counts SETTLE_CYC cycles, then goes to CONVERT.
- CONVERT:
  - adc_start=1 for exactly this cycle.
  - Clears the timeout counter and goes to WAIT_DONE.
- WAIT_DONE:
  - On adc_done, add adc_mem and adc_piezo to two accumulators, each 16+AVG_LOG2 bits wide (no overflow possible).
  - If this was conversion 2^AVG_LOG2−1, go to PUBLISH; otherwise go back to CONVERT.
  - If the timeout counter reaches ADC_TIMEOUT:
    - set timeout_err;
    - discard the accumulators;
    - go to NEXT without publishing.
- PUBLISH:
  - memristor_ref ← acc_mem>>AVG_LOG2 and piezo_ref ← acc_piezo>>AVG_LOG2 (truncating).
  - ch_sign_o ← mux_sel.
  - control_rdy=1 for one cycle; accumulators clear.
- NEXT:
  - Select the next higher set bit of frame_mask and go to SETTLE.
  - If there is none, pulse frame_done. Then:
    - if enable=1, re-latch ch_mask and restart at its lowest set bit (wrap-around);
    - otherwise go to IDLE.
- Published outputs hold their value until the next PUBLISH; there is no back-pressure.
- adc_done outside WAIT_DONE is ignored.
- enable deassertion mid-frame: the current frame completes, then the block goes to IDLE.
- ch_mask changes take effect only at frame start.
- err_clr and a new timeout in the same cycle: set wins.

## Timing
- Reset values:
  - IDLE;
  - mux_sel=4'b0000, adc_start=0;
  - memristor_ref=0, piezo_ref=0, ch_sign_o=0;
  - control_rdy=0, frame_done=0, timeout_err=0;
  - accumulators and counters 0.
- Reset mid-operation aborts immediately; nothing is published.
- All outputs are registered.
- adc_start is high in the cycle after the edge that enters CONVERT.
- The final adc_done at edge k gives control_rdy=1 in cycle k+1, with the data and tag updated at the same edge.
- If the ADC responds L cycles after adc_start, per-channel period = SETTLE_CYC + 2^AVG_LOG2·(L+1) + 2 cycles.

## Structure
- Package mem_frame_pkg holds:
  - state enum;
  - one-hot channel constants CH0..CH3;
  - function lowest_set_above(mask, idx).
- One sub-module, mem_avg_acc (clear/add/shift-average), instantiated twice: memristor and piezo.

## Test plan
- Reset, enable=1, ch_mask=4'b0010, ADC returns mem 6400 / piezo 6000 with L=3 → control_rdy once per 16+4·4+2=34 cycles, memristor_ref=6400, piezo_ref=6000, ch_sign_o=4'b0010, frame_done each pulse.
- ch_mask=4'b1111, mem samples 1,2,3,6 on channel 0 → memristor_ref=3 (12>>2). Tags 0001,0010,0100,1000 in order, then frame_done, then wrap to 0001.
- adc_done withheld on channel 2 → timeout_err=1 after 1023 cycles, no publish for 0100, channel 3 still published. err_clr then clears the flag.
- enable dropped during channel 1 of mask 4'b0011 → channel 1 published, frame_done, then IDLE with mux_sel held and no further adc_start.
- ch_mask=0 with enable=1 → stays in IDLE, adc_start never asserted.
- rst asserted in WAIT_DONE → all outputs return to reset values asynchronously. A spurious adc_done afterwards is ignored.

Source files
------------

// File: rtl/mem_frame_sampler_pkg.sv
// rtl/mem_frame_sampler_pkg.sv - shared types, channel constants and mask helper for the MEM frame sampler
package mem_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT_DONE,
        ST_PUBLISH,
        ST_NEXT
    } state_t;

    localparam logic [3:0] CH0 = 4'b0001;
    localparam logic [3:0] CH1 = 4'b0010;
    localparam logic [3:0] CH2 = 4'b0100;
    localparam logic [3:0] CH3 = 4'b1000;

    // One-hot of the lowest mask bit strictly above the one-hot idx; idx == 0 selects the lowest bit overall.
    function automatic logic [3:0] lowest_set_above(input logic [3:0] mask, input logic [3:0] idx);
        logic [3:0] above;
        above = (idx == 4'b0000) ? mask : (mask & ~((idx << 1) - 4'd1));
        if (above[0]) return CH0;
        else if (above[1]) return CH1;
        else if (above[2]) return CH2;
        else if (above[3]) return CH3;
        else return 4'b0000;
    endfunction

endpackage

// File: rtl/mem_frame_sampler_if.sv
// rtl/mem_frame_sampler_if.sv - analog mux and dual-input ADC handshake bundle
interface mem_frame_sampler_if;
    logic [3:0]  mux_sel;
    logic        adc_start;
    logic        adc_done;
    logic [15:0] adc_mem;
    logic [15:0] adc_piezo;

    modport master (
        output mux_sel,
        output adc_start,
        input  adc_done,
        input  adc_mem,
        input  adc_piezo
    );

    modport slave (
        input  mux_sel,
        input  adc_start,
        output adc_done,
        output adc_mem,
        output adc_piezo
    );
endinterface

// File: rtl/mem_frame_sampler_avg_acc.sv
// rtl/mem_frame_sampler_avg_acc.sv - clear/add accumulator with power-of-two averaging
module mem_avg_acc #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        add,
    input  logic [15:0] sample,
    output logic [15:0] avg_next
);
    localparam int ACC_W = 16 + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(sample);

    // Average including the sample being added this cycle, so the final sum can publish at the same edge.
    assign avg_next = 16'(sum >> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end
endmodule

// File: rtl/mem_frame_sampler.sv
// rtl/mem_frame_sampler.sv - scans masked tactile channels and publishes averaged memristor/piezo pairs
module mem_frame_sampler
    import mem_frame_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int AVG_LOG2    = 2,
    parameter int ADC_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [3:0]          ch_mask,
    input  logic                err_clr,
    mem_frame_sampler_if.master adc,
    output logic [15:0]         memristor_ref,
    output logic [15:0]         piezo_ref,
    output logic [3:0]          ch_sign_o,
    output logic                control_rdy,
    output logic                frame_done,
    output logic                timeout_err
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(ADC_TIMEOUT + 1);
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TOUT_LAST   = TW'(ADC_TIMEOUT - 1);
    localparam logic [CW-1:0] CONV_LAST   = CW'((1 << AVG_LOG2) - 1);

    state_t          state;
    state_t          state_d;
    logic [3:0]      frame_mask;
    logic [3:0]      mask_d;
    logic [3:0]      sel_q;
    logic [3:0]      sel_d;
    logic [3:0]      nxt_ch;
    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   tout_cnt;
    logic [CW-1:0]   conv_cnt;
    logic            start_q;
    logic            acc_add;
    logic            acc_clear;
    logic            fire_publish;
    logic            fire_timeout;
    logic            fd_d;
    logic [15:0]     avg_mem;
    logic [15:0]     avg_piezo;

    assign adc.mux_sel   = sel_q;
    assign adc.adc_start = start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        mask_d       = frame_mask;
        sel_d        = sel_q;
        acc_add      = 1'b0;
        fire_publish = 1'b0;
        fire_timeout = 1'b0;
        nxt_ch       = lowest_set_above(frame_mask, sel_q);
        case (state)
            ST_IDLE: begin
                if (enable && (ch_mask != 4'b0000)) begin
                    mask_d  = ch_mask;
                    sel_d   = lowest_set_above(ch_mask, 4'b0000);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the last timeout cycle still counts as a completed conversion.
                if (adc.adc_done) begin
                    acc_add = 1'b1;
                    if (conv_cnt == CONV_LAST) begin
                        fire_publish = 1'b1;
                        state_d      = ST_PUBLISH;
                    end else begin
                        state_d = ST_CONVERT;
                    end
                end else if (tout_cnt == TOUT_LAST) begin
                    fire_timeout = 1'b1;
                    state_d      = ST_NEXT;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (nxt_ch != 4'b0000) begin
                    sel_d   = nxt_ch;
                    state_d = ST_SETTLE;
                end else if (enable && (ch_mask != 4'b0000)) begin
                    mask_d  = ch_mask;
                    sel_d   = lowest_set_above(ch_mask, 4'b0000);
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        fd_d      = (state_d == ST_NEXT) && (nxt_ch == 4'b0000);
        acc_clear = (state == ST_PUBLISH) || fire_timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_mask    <= 4'b0000;
            sel_q         <= 4'b0000;
            settle_cnt    <= '0;
            tout_cnt      <= '0;
            conv_cnt      <= '0;
            start_q       <= 1'b0;
            control_rdy   <= 1'b0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            memristor_ref <= 16'h0000;
            piezo_ref     <= 16'h0000;
            ch_sign_o     <= 4'b0000;
        end else begin
            frame_mask  <= mask_d;
            sel_q       <= sel_d;
            settle_cnt  <= ((state == ST_SETTLE) && (state_d == ST_SETTLE)) ? settle_cnt + SW'(1) : '0;
            tout_cnt    <= (state == ST_WAIT_DONE) ? tout_cnt + TW'(1) : '0;
            start_q     <= (state_d == ST_CONVERT);
            control_rdy <= fire_publish;
            frame_done  <= fd_d;
            if (fire_publish || fire_timeout) begin
                conv_cnt <= '0;
            end else if (acc_add) begin
                conv_cnt <= conv_cnt + CW'(1);
            end
            if (fire_publish) begin
                memristor_ref <= avg_mem;
                piezo_ref     <= avg_piezo;
                ch_sign_o     <= sel_q;
            end
            // A timeout in the same cycle as err_clr keeps the flag set.
            if (fire_timeout) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    mem_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc_mem (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .add      (acc_add),
        .sample   (adc.adc_mem),
        .avg_next (avg_mem)
    );

    mem_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc_piezo (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .add      (acc_add),
        .sample   (adc.adc_piezo),
        .avg_next (avg_piezo)
    );
endmodule

// File: tb/tb_mem_frame_sampler.sv
// tb/tb_mem_frame_sampler.sv - randomized ADC responder with behavioural publish model for mem_frame_sampler
module tb_mem_frame_sampler;
    localparam int SETTLE_CYC  = 16;
    localparam int AVG_LOG2    = 2;
    localparam int ADC_TIMEOUT = 1023;
    localparam int NCONV       = 1 << AVG_LOG2;

    typedef struct {
        int         cyc;
        int         mem;
        int         piezo;
        logic [3:0] tag;
    } pub_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  ch_mask;
    logic        err_clr;
    logic [15:0] memristor_ref;
    logic [15:0] piezo_ref;
    logic [3:0]  ch_sign_o;
    logic        control_rdy;
    logic        frame_done;
    logic        timeout_err;

    mem_frame_sampler_if adc ();

    mem_frame_sampler #(
        .SETTLE_CYC  (SETTLE_CYC),
        .AVG_LOG2    (AVG_LOG2),
        .ADC_TIMEOUT (ADC_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .ch_mask       (ch_mask),
        .err_clr       (err_clr),
        .adc           (adc),
        .memristor_ref (memristor_ref),
        .piezo_ref     (piezo_ref),
        .ch_sign_o     (ch_sign_o),
        .control_rdy   (control_rdy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model state
    pub_t       exp_pub[$];
    int         exp_fd[$];
    int         pub_cycles[$];
    logic [3:0] pub_tags[$];
    int         pub_mem[$];
    int         pub_pz[$];
    logic [3:0] model_mask;
    logic [3:0] model_ch;
    logic       model_terr = 1'b0;
    int         terr_at = -1;
    logic       clr_prev = 1'b0;
    int         last_m = 0;
    int         last_p = 0;
    logic [3:0] last_tag = 4'b0000;
    logic       chk_en = 1'b0;
    int         n_starts = 0;
    int         fd_seen = 0;

    // ADC behaviour knobs
    logic       adc_auto = 1'b1;
    logic [3:0] withhold = 4'b0000;
    int         fixed_lat = 0;
    logic       data_fixed = 1'b0;
    logic [15:0] fix_m = 16'd0;
    logic [15:0] fix_p = 16'd0;
    int         tab_left = 0;
    int         tab_m[4] = '{1, 2, 3, 6};
    int         tab_p[4] = '{10, 20, 30, 41};

    function automatic logic [3:0] first_ch(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    function automatic int ch_idx(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i;
        return -1;
    endfunction

    function automatic logic is_last(input logic [3:0] m, input logic [3:0] c);
        for (int i = ch_idx(c) + 1; i < 4; i++) if (m[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] next_ch(input logic [3:0] m, input logic [3:0] c);
        for (int i = ch_idx(c) + 1; i < 4; i++) if (m[i]) return 4'(1 << i);
        return first_ch(m);
    endfunction

    // ADC responder: answers each adc_start after a latency and records what must be published.
    int          conv_n = 0;
    int          sum_m = 0;
    int          sum_p = 0;
    int          c0;
    int          lat;
    logic [15:0] sm;
    logic [15:0] sp;
    initial begin
        adc.adc_done  = 1'b0;
        adc.adc_mem   = 16'd0;
        adc.adc_piezo = 16'd0;
        forever begin
            @(negedge clk);
            if (adc_auto && adc.adc_start === 1'b1) begin
                c0 = cyc;
                check("mux_sel_at_start", {28'd0, adc.mux_sel}, {28'd0, model_ch});
                if ((withhold & model_ch) != 4'b0000) begin
                    terr_at = c0 + ADC_TIMEOUT + 1;
                    if (is_last(model_mask, model_ch)) exp_fd.push_back(c0 + ADC_TIMEOUT + 1);
                    conv_n = 0; sum_m = 0; sum_p = 0;
                    model_ch = next_ch(model_mask, model_ch);
                end else begin
                    lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
                    repeat (lat) @(posedge clk);
                    #1;
                    if (tab_left > 0) begin
                        sm = 16'(tab_m[4 - tab_left]);
                        sp = 16'(tab_p[4 - tab_left]);
                        tab_left--;
                    end else if (data_fixed) begin
                        sm = fix_m;
                        sp = fix_p;
                    end else begin
                        sm = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
                        sp = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
                    end
                    adc.adc_done  = 1'b1;
                    adc.adc_mem   = sm;
                    adc.adc_piezo = sp;
                    conv_n++;
                    sum_m += int'(sm);
                    sum_p += int'(sp);
                    if (conv_n == NCONV) begin
                        exp_pub.push_back('{cyc: cyc + 1, mem: sum_m / NCONV, piezo: sum_p / NCONV, tag: model_ch});
                        if (is_last(model_mask, model_ch)) exp_fd.push_back(cyc + 2);
                        model_ch = next_ch(model_mask, model_ch);
                        conv_n = 0; sum_m = 0; sum_p = 0;
                    end
                    @(posedge clk);
                    #1;
                    adc.adc_done  = 1'b0;
                    adc.adc_mem   = 16'($urandom_range(0, 65535));
                    adc.adc_piezo = 16'($urandom_range(0, 65535));
                end
            end
        end
    end

    // Cycle-by-cycle comparison of the published outputs against the model.
    pub_t cur;
    logic rdy_e;
    logic fd_e;
    always @(negedge clk) begin
        if (adc.adc_start === 1'b1) n_starts++;
        if (frame_done === 1'b1) fd_seen++;
        if (chk_en) begin
            while (exp_pub.size() > 0 && exp_pub[0].cyc < cyc) void'(exp_pub.pop_front());
            while (exp_fd.size() > 0 && exp_fd[0] < cyc) void'(exp_fd.pop_front());
            rdy_e = (exp_pub.size() > 0) && (exp_pub[0].cyc == cyc);
            check("control_rdy", {31'd0, control_rdy}, {31'd0, rdy_e});
            if (rdy_e) begin
                cur = exp_pub.pop_front();
                last_m   = cur.mem;
                last_p   = cur.piezo;
                last_tag = cur.tag;
                pub_cycles.push_back(cyc);
                pub_tags.push_back(ch_sign_o);
                pub_mem.push_back(int'(memristor_ref));
                pub_pz.push_back(int'(piezo_ref));
            end
            check("memristor_ref", {16'd0, memristor_ref}, last_m);
            check("piezo_ref", {16'd0, piezo_ref}, last_p);
            check("ch_sign_o", {28'd0, ch_sign_o}, {28'd0, last_tag});
            fd_e = (exp_fd.size() > 0) && (exp_fd[0] == cyc);
            if (fd_e) void'(exp_fd.pop_front());
            check("frame_done", {31'd0, frame_done}, {31'd0, fd_e});
            if (terr_at == cyc) model_terr = 1'b1;
            else if (clr_prev) model_terr = 1'b0;
            check("timeout_err", {31'd0, timeout_err}, {31'd0, model_terr});
        end
        clr_prev = err_clr;
    end

    task automatic start_scan(input logic [3:0] m);
        pub_cycles.delete();
        pub_tags.delete();
        pub_mem.delete();
        pub_pz.delete();
        model_mask = m;
        model_ch   = first_ch(m);
        ch_mask    = m;
        enable     = 1'b1;
    endtask

    task automatic drain(input int n);
        enable = 1'b0;
        repeat (n) @(negedge clk);
        check("drain_pub_queue_empty", exp_pub.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux_sel"}, {28'd0, adc.mux_sel}, 0);
        check({tag, "_adc_start"}, {31'd0, adc.adc_start}, 0);
        check({tag, "_memristor_ref"}, {16'd0, memristor_ref}, 0);
        check({tag, "_piezo_ref"}, {16'd0, piezo_ref}, 0);
        check({tag, "_ch_sign_o"}, {28'd0, ch_sign_o}, 0);
        check({tag, "_control_rdy"}, {31'd0, control_rdy}, 0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, 0);
    endtask

    int t;
    int s0;
    int fd0;
    initial begin
        rst = 1'b1; enable = 1'b0; ch_mask = 4'b0000; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;

        // Single channel, fixed data and latency 3: period 16 + 4*4 + 2 = 34.
        fixed_lat = 3; data_fixed = 1'b1; fix_m = 16'd6400; fix_p = 16'd6000;
        fd0 = fd_seen;
        start_scan(4'b0010);
        t = 0; while (pub_cycles.size() < 3 && t < 400) begin @(negedge clk); t++; end
        check("A_publish_count", {31'd0, pub_cycles.size() >= 3}, 1);
        check("A_period_0", pub_cycles[1] - pub_cycles[0], 34);
        check("A_period_1", pub_cycles[2] - pub_cycles[1], 34);
        check("A_mem_literal", pub_mem[0], 6400);
        check("A_piezo_literal", pub_pz[0], 6000);
        check("A_tag_literal", {28'd0, pub_tags[0]}, 4'b0010);
        check("A_frame_done_pulses", {31'd0, (fd_seen - fd0) >= 2}, 1);
        drain(120);

        // All four channels, first channel averages 1,2,3,6 and 10,20,30,41.
        fixed_lat = 0; data_fixed = 1'b0; tab_left = 4;
        start_scan(4'b1111);
        t = 0; while (pub_cycles.size() < 12 && t < 1000) begin @(negedge clk); t++; end
        check("B_publish_count", {31'd0, pub_cycles.size() >= 12}, 1);
        check("B_mem_avg_literal", pub_mem[0], 3);
        check("B_piezo_avg_literal", pub_pz[0], 25);
        check("B_tag0", {28'd0, pub_tags[0]}, 4'b0001);
        check("B_tag1", {28'd0, pub_tags[1]}, 4'b0010);
        check("B_tag2", {28'd0, pub_tags[2]}, 4'b0100);
        check("B_tag3", {28'd0, pub_tags[3]}, 4'b1000);
        check("B_tag4_wrap", {28'd0, pub_tags[4]}, 4'b0001);
        drain(250);

        // Random masks with random data and latency.
        for (int k = 0; k < 3; k++) begin
            start_scan(4'($urandom_range(1, 15)));
            t = 0; while (pub_cycles.size() < 6 && t < 800) begin @(negedge clk); t++; end
            check("C_publish_count", {31'd0, pub_cycles.size() >= 6}, 1);
            drain(250);
        end

        // Channel 2 never answers: timeout, no publish for it, channel 3 still published.
        withhold = 4'b0100;
        start_scan(4'b1111);
        t = 0; while (pub_tags.size() < 2 && t < 300) begin @(negedge clk); t++; end
        enable = 1'b0;
        t = 0; while (pub_tags.size() < 3 && t < 1500) begin @(negedge clk); t++; end
        check("D_tag0", {28'd0, pub_tags[0]}, 4'b0001);
        check("D_tag1", {28'd0, pub_tags[1]}, 4'b0010);
        check("D_tag2_skips_ch2", {28'd0, pub_tags[2]}, 4'b1000);
        check("D_timeout_err_set", {31'd0, timeout_err}, 1);
        drain(100);
        withhold = 4'b0000;
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check("D_err_clr", {31'd0, timeout_err}, 0);

        // enable dropped during channel 1 of mask 0011.
        fixed_lat = 3;
        start_scan(4'b0011);
        t = 0; while (pub_tags.size() < 1 && t < 200) begin @(negedge clk); t++; end
        repeat (20) @(negedge clk);
        enable = 1'b0;
        fd0 = fd_seen;
        t = 0; while (fd_seen == fd0 && t < 200) begin @(negedge clk); t++; end
        check("E_frame_done_seen", {31'd0, fd_seen > fd0}, 1);
        check("E_publish_count", pub_tags.size(), 2);
        check("E_tag1", {28'd0, pub_tags[1]}, 4'b0010);
        s0 = n_starts;
        repeat (100) @(negedge clk);
        check("E_no_adc_start_in_idle", n_starts - s0, 0);
        check("E_mux_sel_held", {28'd0, adc.mux_sel}, 4'b0010);

        // Empty mask keeps the block idle.
        start_scan(4'b0000);
        s0 = n_starts;
        repeat (60) @(negedge clk);
        check("F_no_adc_start", n_starts - s0, 0);
        enable = 1'b0;

        // Reset while waiting for a conversion.
        withhold = 4'b1111;
        start_scan(4'b0001);
        s0 = n_starts;
        t = 0; while (n_starts == s0 && t < 100) begin @(negedge clk); t++; end
        check("G_reached_convert", {31'd0, n_starts > s0}, 1);
        repeat (5) @(posedge clk);
        #3;
        chk_en = 1'b0;
        adc_auto = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_pub.delete(); exp_fd.delete();
        terr_at = -1; model_terr = 1'b0;
        last_m = 0; last_p = 0; last_tag = 4'b0000;
        enable = 1'b0; withhold = 4'b0000;
        @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;
        s0 = n_starts;
        adc.adc_done = 1'b1; adc.adc_mem = 16'h1234; adc.adc_piezo = 16'h4321;
        repeat (2) @(posedge clk);
        #1 adc.adc_done = 1'b0;
        repeat (30) @(negedge clk);
        check("G_spurious_done_no_start", n_starts - s0, 0);
        check("G_refs_still_zero", {16'd0, memristor_ref}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
